// File: rtl/byte_unpack_pkg.sv
// Shared types and constants for the byte unpack controller.
package byte_unpack_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    localparam logic [2:0] SEL_NONE = 3'd0;
    localparam logic [2:0] SEL_B0   = 3'd1;
    localparam logic [2:0] SEL_B1   = 3'd2;
    localparam logic [2:0] SEL_B2   = 3'd3;
    localparam logic [2:0] SEL_B3   = 3'd4;
    localparam int unsigned MAX_LEN = 4;

    // Zero stays zero (word is dropped); anything above MAX_LEN is clamped.
    function automatic logic [2:0] eff_len(input logic [2:0] len);
        if (len > 3'(MAX_LEN)) return 3'(MAX_LEN);
        return len;
    endfunction

endpackage

// File: rtl/byte_lane_select.sv
// Combinational byte-lane mux: lane 1 is [7:0] up to lane 4 at [31:24]; other selects give 0.
module byte_lane_select
    import byte_unpack_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [2:0]  sel_i,
    output logic [7:0]  byte_o
);

    always_comb begin
        byte_o = 8'h00;
        case (sel_i)
            SEL_B0:  byte_o = word_i[7:0];
            SEL_B1:  byte_o = word_i[15:8];
            SEL_B2:  byte_o = word_i[23:16];
            SEL_B3:  byte_o = word_i[31:24];
            default: byte_o = 8'h00;
        endcase
    end

endmodule

// File: rtl/byte_unpack_ctrl.sv
// Unpacks an accepted 32-bit word into 1..4 bytes, LSB first, over a valid/ready stream.
// Optional statistics counters are built when BYTE_UNPACK_STATS_EN is defined.
module byte_unpack_ctrl
    import byte_unpack_pkg::*;
#(
    parameter int N     = 32,
    parameter int CNT_W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_word,
    input  logic [2:0]   in_len,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [7:0]   out_byte,
    output logic [2:0]   out_sel,
    output logic         out_last,
    output logic         busy
`ifdef BYTE_UNPACK_STATS_EN
    ,
    output logic [CNT_W-1:0] words_cnt,
    output logic [CNT_W-1:0] bytes_cnt
`endif
);

    if (N != 32 || CNT_W < 1) begin : g_bad_params
        $error("byte_unpack_ctrl: N must be 32 and CNT_W at least 1");
    end

    state_e       state_q;
    logic [N-1:0] word_q;
    logic [2:0]   len_q;
    logic [2:0]   sel_q;

    logic [2:0] len_eff;
    logic       accept;
    logic       out_hs;
    logic       last_hs;

    // Handshakes: a transfer happens on a rising edge where valid && ready.
    // in_ready opens in SEND only while the final byte is being taken, so a
    // follow-on word can be loaded without a bubble.
    assign len_eff   = eff_len(in_len);
    assign busy      = (state_q == SEND);
    assign out_valid = busy;
    assign out_sel   = sel_q;
    assign out_last  = busy && (sel_q == len_q);
    assign out_hs    = out_valid && out_ready;
    assign last_hs   = out_hs && out_last;
    assign in_ready  = !busy || last_hs;
    assign accept    = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            word_q  <= '0;
            len_q   <= 3'd0;
            sel_q   <= SEL_NONE;
        end else if (accept && len_eff != 3'd0) begin
            state_q <= SEND;
            word_q  <= in_word;
            len_q   <= len_eff;
            sel_q   <= SEL_B0;
        end else if (last_hs) begin
            state_q <= IDLE;
            sel_q   <= SEL_NONE;
        end else if (out_hs) begin
            sel_q   <= sel_q + 3'd1;
        end
    end

    byte_lane_select u_lane_sel (
        .word_i (word_q),
        .sel_i  (sel_q),
        .byte_o (out_byte)
    );

`ifdef BYTE_UNPACK_STATS_EN
    logic [CNT_W-1:0] words_cnt_q, words_cnt_d;
    logic [CNT_W-1:0] bytes_cnt_q, bytes_cnt_d;

    // Both counters stick at all-ones rather than wrapping.
    always_comb begin
        words_cnt_d = words_cnt_q;
        bytes_cnt_d = bytes_cnt_q;
        if (accept && len_eff != 3'd0 && words_cnt_q != '1) words_cnt_d = words_cnt_q + 1'b1;
        if (out_hs && bytes_cnt_q != '1) bytes_cnt_d = bytes_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            words_cnt_q <= '0;
            bytes_cnt_q <= '0;
        end else begin
            words_cnt_q <= words_cnt_d;
            bytes_cnt_q <= bytes_cnt_d;
        end
    end

    assign words_cnt = words_cnt_q;
    assign bytes_cnt = bytes_cnt_q;
`endif

endmodule

// File: tb/tb_byte_unpack_ctrl.sv
// Directed bench for byte_unpack_ctrl; counter checks run when BYTE_UNPACK_STATS_EN is defined.
module tb_byte_unpack_ctrl;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_word;
    logic [2:0]  in_len;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_byte;
    logic [2:0]  out_sel;
    logic        out_last;
    logic        busy;

    int checks   = 0;
    int failures = 0;

`ifdef BYTE_UNPACK_STATS_EN
    logic [1:0] words_cnt;
    logic [1:0] bytes_cnt;

    byte_unpack_ctrl #(.N(32), .CNT_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word), .in_len(in_len),
        .out_valid(out_valid), .out_ready(out_ready), .out_byte(out_byte),
        .out_sel(out_sel), .out_last(out_last), .busy(busy),
        .words_cnt(words_cnt), .bytes_cnt(bytes_cnt)
    );
`else
    byte_unpack_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word), .in_len(in_len),
        .out_valid(out_valid), .out_ready(out_ready), .out_byte(out_byte),
        .out_sel(out_sel), .out_last(out_last), .busy(busy)
    );
`endif

    // clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk_byte(input string tag, input logic [7:0] b, input logic [2:0] sel,
                            input logic last);
        check({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, ".byte"},  {24'd0, out_byte},  {24'd0, b});
        check({tag, ".sel"},   {29'd0, out_sel},   {29'd0, sel});
        check({tag, ".last"},  {31'd0, out_last},  {31'd0, last});
    endtask

    task automatic chk_idle(input string tag);
        check({tag, ".valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, ".busy"},  {31'd0, busy},      32'd0);
        check({tag, ".sel"},   {29'd0, out_sel},   32'd0);
        check({tag, ".byte"},  {24'd0, out_byte},  32'd0);
        check({tag, ".rdy"},   {31'd0, in_ready},  32'd1);
    endtask

    task automatic offer(input logic [31:0] w, input logic [2:0] len);
        in_valid = 1'b1;
        in_word  = w;
        in_len   = len;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_word   = 32'd0;
        in_len    = 3'd0;
        out_ready = 1'b1;
        repeat (2) tick();
        chk_idle("reset");
        rst_n = 1'b1;
        tick();

        // 4-byte word, consumer always ready
        offer(32'hDDCCBBAA, 3'd4);
        check("t1.accept_rdy", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        chk_byte("t1.b0", 8'hAA, 3'd1, 1'b0);
        tick(); chk_byte("t1.b1", 8'hBB, 3'd2, 1'b0);
        tick(); chk_byte("t1.b2", 8'hCC, 3'd3, 1'b0);
        tick(); chk_byte("t1.b3", 8'hDD, 3'd4, 1'b1);
        tick(); chk_idle("t1.end");

        // Backpressure holds the first byte steady
        out_ready = 1'b0;
        offer(32'h44332211, 3'd2);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk_byte("t2.hold", 8'h11, 3'd1, 1'b0);
            check("t2.hold_nrdy", {31'd0, in_ready}, 32'd0);
            tick();
        end
        chk_byte("t2.hold_end", 8'h11, 3'd1, 1'b0);
        out_ready = 1'b1;
        tick(); chk_byte("t2.b1", 8'h22, 3'd2, 1'b1);
        check("t2.last_rdy", {31'd0, in_ready}, 32'd1);
        tick(); chk_idle("t2.end");

        // Back-to-back words, second loaded on the last-byte handshake
        offer(32'h0000A1B2, 3'd2);
        tick();
        in_valid = 1'b0;
        chk_byte("t3.w0b0", 8'hB2, 3'd1, 1'b0);
        tick(); chk_byte("t3.w0b1", 8'hA1, 3'd2, 1'b1);
        offer(32'h0000C3D4, 3'd1);
        check("t3.chain_rdy", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        chk_byte("t3.w1b0", 8'hD4, 3'd1, 1'b1);
        tick(); chk_idle("t3.end");

        // Zero length is swallowed; seven is clamped to four
        offer(32'h5A5A5A5A, 3'd0);
        check("t4.len0_rdy", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        chk_idle("t4.len0_a");
        tick(); chk_idle("t4.len0_b");
        offer(32'h87654321, 3'd7);
        tick();
        in_valid = 1'b0;
        chk_byte("t4.l7b0", 8'h21, 3'd1, 1'b0);
        tick(); chk_byte("t4.l7b1", 8'h43, 3'd2, 1'b0);
        tick(); chk_byte("t4.l7b2", 8'h65, 3'd3, 1'b0);
        tick(); chk_byte("t4.l7b3", 8'h87, 3'd4, 1'b1);
        tick(); chk_idle("t4.end");

        // Reset mid-word, then restart from lane 1
        offer(32'h12345678, 3'd4);
        tick();
        in_valid = 1'b0;
        chk_byte("t5.b0", 8'h78, 3'd1, 1'b0);
        tick(); chk_byte("t5.b1", 8'h56, 3'd2, 1'b0);
        tick(); chk_byte("t5.b2", 8'h34, 3'd3, 1'b0);
        rst_n = 1'b0;
        #1;
        chk_idle("t5.rst");
        tick();
        rst_n = 1'b1;
        offer(32'hCAFEF00D, 3'd3);
        tick();
        in_valid = 1'b0;
        chk_byte("t5.post_b0", 8'h0D, 3'd1, 1'b0);
        tick(); chk_byte("t5.post_b1", 8'hF0, 3'd2, 1'b0);
        tick(); chk_byte("t5.post_b2", 8'hFE, 3'd3, 1'b1);
        tick(); chk_idle("t5.end");

`ifdef BYTE_UNPACK_STATS_EN
        // Five single-byte words saturate the 2-bit counters at 3
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("t6.words_rst", {30'd0, words_cnt}, 32'd0);
        check("t6.bytes_rst", {30'd0, bytes_cnt}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            offer(32'h000000F0 + i, 3'd1);
            tick();
            chk_byte("t6.byte", 8'hF0 + 8'(i), 3'd1, 1'b1);
        end
        in_valid = 1'b0;
        tick();
        chk_idle("t6.end");
        check("t6.words_sat", {30'd0, words_cnt}, 32'd3);
        check("t6.bytes_sat", {30'd0, bytes_cnt}, 32'd3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/byte_unpack_ctrl.md
BYTE_UNPACK_CTRL -- requirements
Module: byte_unpack_ctrl

Interface
REQ-001 SHALL have parameter N, default 32, giving the input word width; only 32 is supported.
REQ-002 SHALL have parameter CNT_W, default 16, giving the width of the statistics counters.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit: the word offer is valid.
REQ-006 SHALL have port in_ready, output, 1 bit: the controller accepts a word.
REQ-007 SHALL have port in_word, input, N bits: the word to unpack.
REQ-008 SHALL have port in_len, input, 3 bits: the number of bytes to emit, legal range 1..4.
REQ-009 SHALL have port out_valid, output, 1 bit: the byte is valid.
REQ-010 SHALL have port out_ready, input, 1 bit: the consumer accepts the byte.
REQ-011 SHALL have port out_byte, output, 8 bits: the current byte.
REQ-012 SHALL have port out_sel, output, 3 bits: the current byte-lane select; 1=[7:0], 2=[15:8], 3=[23:16], 4=[31:24], 0=none.
REQ-013 SHALL have port out_last, output, 1 bit: the current byte is the final byte of its word.
REQ-014 SHALL have port busy, output, 1 bit: the controller is in state SEND.

Function
REQ-015 SHALL implement FSM states IDLE and SEND.
- IDLE -> SEND: in_valid && in_ready with effective length ≥1.
- SEND -> IDLE: last-byte handshake with no new word accepted in the same cycle.
REQ-016 SHALL assert in_ready in IDLE, and in SEND only during the cycle of the last-byte handshake (out_valid && out_ready && out_last); this is a combinational path from out_ready.
REQ-017 SHALL register in_word and the effective length on acceptance, so that out_valid rises in the cycle after acceptance (1-cycle latency).
REQ-018 SHALL derive the effective length as follows: in_len 0 → word accepted and discarded, no bytes emitted, state stays IDLE; in_len >4 → clamped to 4.
REQ-019 SHALL emit bytes LSB-first: out_sel = 1, 2, ..., len; out_byte = the registered word lane selected by out_sel.
REQ-020 SHALL advance out_sel only on an out_valid && out_ready handshake, and SHALL hold out_byte, out_sel and out_last stable while out_valid && !out_ready.
REQ-021 SHALL assert out_last iff the current out_sel equals the final lane for the word's effective length.
REQ-022 SHALL, when a new word is accepted in the same cycle as the last-byte handshake, load that word and present its first byte in the next cycle with no bubble.
REQ-023 SHALL hold out_sel=0, out_byte=0 and out_valid=0 in IDLE.

Reset
REQ-024 SHALL, on rst_n low, immediately enter IDLE, clear all outputs and counters to 0, drive in_ready=1 once IDLE is reached, and discard any partially sent word; SHALL resume operation from the first rising edge of clk after rst_n deasserts.

Configuration
REQ-025 SHALL, with BYTE_UNPACK_STATS_EN defined, add outputs words_cnt and bytes_cnt (each CNT_W bits), incremented per accepted word with length ≥1 and per byte handshake respectively, each saturating at all-ones.
REQ-026 SHALL, without BYTE_UNPACK_STATS_EN, omit these ports and their logic entirely.

Structure
REQ-027 SHALL place the state enum, the SEL_NONE and SEL_B0..SEL_B3 constants, and MAX_LEN=4 in package byte_unpack_pkg.
REQ-028 SHALL implement lane selection in the single combinational sub-module byte_lane_select (word, sel → byte, 0 for illegal sel).

Verification
REQ-029 SHALL verify: word 0xDDCCBBAA, len 4, out_ready=1 → bytes AA, BB, CC, DD on cycles T+1..T+4, out_sel 1..4, out_last only with DD.
REQ-030 SHALL verify: word 0x44332211, len 2, out_ready low for 3 cycles at byte 0x11 → 0x11 held stable, then 0x22 with out_last, then IDLE.
REQ-031 SHALL verify: back-to-back words 0x0000A1B2 (len 2) and 0x0000C3D4 (len 1) → bytes B2, A1, D4 on consecutive cycles, no bubble.
REQ-032 SHALL verify: len 0 → word accepted, no out_valid, busy stays 0; len 7 → 4 bytes emitted.
REQ-033 SHALL verify: rst_n pulsed low after byte 2 of 4 → immediately out_valid=0, out_sel=0; first post-reset word emits from lane 1.
REQ-034 SHALL verify, with BYTE_UNPACK_STATS_EN and CNT_W=2: 5 words of len 1 → words_cnt saturates at 3.
